// File: rtl/booth_mul_pipe_if.sv
// Operand/result bus of the pipelined Booth multiplier.
// master = issue/consumer side, slave = multiplier.
interface booth_mul_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);

  logic [WIDTH-1:0]   data1;
  logic [WIDTH-1:0]   data2;
  logic               sign_i;
  logic [TAG_W-1:0]   tag_i;
  logic               valid_i;
  logic               ready_o;
  logic [2*WIDTH-1:0] res;
  logic [TAG_W-1:0]   tag_o;
  logic               valid_o;
  logic               ready_i;

  modport master (
    output data1, data2, sign_i, tag_i, valid_i, ready_i,
    input  ready_o, res, tag_o, valid_o
  );

  modport slave (
    input  data1, data2, sign_i, tag_i, valid_i, ready_i,
    output ready_o, res, tag_o, valid_o
  );

endinterface

// File: rtl/booth_mul_pipe.sv
// Fully pipelined radix-4 Booth multiplier, signed/unsigned per transaction,
// with tag sideband and a global stall driven by output backpressure.
// Register levels: operands -> Booth recode -> partial products -> carry-save -> result.
module booth_mul_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  booth_mul_pipe_if.slave bus
);

  localparam int unsigned EW  = WIDTH + 2;     // extended operand width
  localparam int unsigned PPW = WIDTH + 3;     // partial-product row width
  localparam int unsigned NPP = WIDTH / 2 + 1; // number of Booth digits
  localparam int unsigned PW  = 2 * WIDTH;     // product width

  // Sum of the constant terms that replace each row's sign extension
  function automatic logic [PW-1:0] sign_corr();
    logic [PW-1:0] c;
    int unsigned   k;
    c = '0;
    for (int unsigned j = 0; j < NPP; j++) begin
      k = WIDTH + 2 + 2 * j;
      if (k < PW) c = c - (PW'(1) << k);
    end
    return c;
  endfunction

  localparam logic [PW-1:0] CORR = sign_corr();

  logic                      stall_c;
  logic                      v1_q, vrc_q, v2_q, v3_q, valid_o_q;
  logic [WIDTH-1:0]          a1_q, b1_q;
  logic                      sign1_q;
  logic [TAG_W-1:0]          tag1_q, tagrc_q, tag2_q, tag3_q, tag_o_q;
  logic [EW-1:0]             arc_d, arc_q;
  logic [NPP-1:0]            one_d, one_q, two_d, two_q, neg_d, neg_q;
  logic [NPP-1:0][PPW-1:0]   pp_d, pp_q;
  logic [PW-1:0]             nbit_d, nbit_q;
  logic [PW-1:0]             sum_d, sum_q, carry_d, carry_q;
  logic [PW-1:0]             res_d, res_q;

  assign stall_c     = valid_o_q & ~bus.ready_i;
  assign bus.ready_o = rst_n & ~stall_c;
  assign bus.res     = res_q;
  assign bus.tag_o   = tag_o_q;
  assign bus.valid_o = valid_o_q;

  // Recode: extend operands per mode and derive Booth digit controls
  always_comb begin
    logic [EW-1:0] bext;
    logic [EW:0]   bx;
    logic          b0, b1, b2;
    arc_d = {{2{sign1_q & a1_q[WIDTH-1]}}, a1_q};
    bext  = {{2{sign1_q & b1_q[WIDTH-1]}}, b1_q};
    bx    = {bext, 1'b0};
    one_d = '0;
    two_d = '0;
    neg_d = '0;
    b0    = 1'b0;
    b1    = 1'b0;
    b2    = 1'b0;
    for (int unsigned j = 0; j < NPP; j++) begin
      b0       = bx[2*j];
      b1       = bx[2*j+1];
      b2       = bx[2*j+2];
      one_d[j] = b1 ^ b0;
      two_d[j] = (b2 & ~b1 & ~b0) | (~b2 & b1 & b0);
      neg_d[j] = b2 & ~(b1 & b0);
    end
  end

  // Partial products: one's-complement rows with inverted sign bit; +1 kept in nbit
  always_comb begin
    logic [PPW-1:0] a3, mag, prod;
    pp_d   = '0;
    nbit_d = '0;
    a3     = {arc_q[EW-1], arc_q};
    mag    = '0;
    prod   = '0;
    for (int unsigned j = 0; j < NPP; j++) begin
      mag           = one_q[j] ? a3 : (two_q[j] ? {arc_q, 1'b0} : '0);
      prod          = neg_q[j] ? ~mag : mag;
      pp_d[j]       = {~prod[PPW-1], prod[PPW-2:0]};
      nbit_d[2*j]   = neg_q[j];
    end
  end

  // Carry-save reduction of all rows plus the sign-correction constant
  always_comb begin
    logic [PW-1:0] row, t;
    sum_d   = PW'(pp_q[0]);
    carry_d = nbit_q;
    row     = '0;
    t       = '0;
    for (int unsigned j = 1; j < NPP; j++) begin
      row     = PW'(pp_q[j]) << (2 * j);
      t       = sum_d ^ carry_d ^ row;
      carry_d = ((sum_d & carry_d) | (sum_d & row) | (carry_d & row)) << 1;
      sum_d   = t;
    end
    t       = sum_d ^ carry_d ^ CORR;
    carry_d = ((sum_d & carry_d) | (sum_d & CORR) | (carry_d & CORR)) << 1;
    sum_d   = t;
  end

  // Final carry-propagate add
  always_comb begin
    res_d = sum_q + carry_q;
  end

  // Stage valids and result register, cleared by reset, frozen on stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      vrc_q     <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      valid_o_q <= 1'b0;
      res_q     <= '0;
      tag_o_q   <= '0;
    end else if (!stall_c) begin
      v1_q      <= bus.valid_i;
      vrc_q     <= v1_q;
      v2_q      <= vrc_q;
      v3_q      <= v2_q;
      valid_o_q <= v3_q;
      if (v3_q) begin
        res_q   <= res_d;
        tag_o_q <= tag3_q;
      end
    end
  end

  // Stage data registers, loaded only when the feeding stage holds a transaction
  always_ff @(posedge clk) begin
    if (!stall_c) begin
      if (bus.valid_i) begin
        a1_q    <= bus.data1;
        b1_q    <= bus.data2;
        sign1_q <= bus.sign_i;
        tag1_q  <= bus.tag_i;
      end
      if (v1_q) begin
        arc_q   <= arc_d;
        one_q   <= one_d;
        two_q   <= two_d;
        neg_q   <= neg_d;
        tagrc_q <= tag1_q;
      end
      if (vrc_q) begin
        pp_q    <= pp_d;
        nbit_q  <= nbit_d;
        tag2_q  <= tagrc_q;
      end
      if (v2_q) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        tag3_q  <= tag2_q;
      end
    end
  end

endmodule
